// File: rtl/glitch_cmd_host.sv
// glitch_cmd_host: sends an opcode + 32-bit argument as 8N1 UART bytes, then waits for one response byte.
// Build option: define GLITCH_CMD_CHECKSUM_EN to append an XOR checksum byte to every command frame.
module glitch_cmd_host #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [7:0]  cmd_op_i,
    input  logic [31:0] cmd_arg_i,
    output logic        uart_tx_o,
    input  logic        uart_rx_i,
    output logic        rsp_valid_o,
    output logic [1:0]  rsp_status_o,
    output logic [7:0]  rsp_byte_o,
    output logic        busy_o
);
    localparam int BIT_CYC  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int BIT_W    = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`ifdef GLITCH_CMD_CHECKSUM_EN
    localparam int NUM_BYTES = 6;
`else
    localparam int NUM_BYTES = 5;
`endif
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BIT_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_HALF  = BIT_W'(HALF_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       BYTE_LAST = 3'(NUM_BYTES - 1);
    localparam logic [3:0]       BIT_PRE   = 4'd15;
    localparam logic [3:0]       BIT_STOP  = 4'd9;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, REPORT} state_t;

    state_t           state_reg;
    logic [7:0]       op_reg;
    logic [31:0]      arg_reg;
    logic [BIT_W-1:0] bit_cnt_reg;
    logic [3:0]       bit_idx_reg;
    logic [2:0]       byte_idx_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;

    logic             rx_meta_reg;
    logic             rx_sync_reg;
    logic             rx_prev_reg;
    logic             rx_busy_reg;
    logic [BIT_W-1:0] rx_cnt_reg;
    logic [3:0]       rx_bit_reg;
    logic [7:0]       rx_shift_reg;
    logic             rx_done_reg;

    logic [7:0]       frame_bytes [NUM_BYTES];
    logic [7:0]       cur_byte;

    // Frame order: opcode, then the argument little-endian.
    assign frame_bytes[0] = op_reg;
    for (genvar gi = 0; gi < 4; gi++) begin : g_arg_bytes
        assign frame_bytes[gi+1] = arg_reg[8*gi +: 8];
    end
`ifdef GLITCH_CMD_CHECKSUM_EN
    assign frame_bytes[5] = op_reg ^ arg_reg[7:0] ^ arg_reg[15:8] ^ arg_reg[23:16] ^ arg_reg[31:24];
`endif
    assign cur_byte = frame_bytes[byte_idx_reg];

    // Receiver runs continuously; rx_done_reg pulses only for bytes with a valid stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_busy_reg  <= 1'b0;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_done_reg  <= 1'b0;
        end else begin
            rx_meta_reg <= uart_rx_i;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            rx_done_reg <= 1'b0;
            if (!rx_busy_reg) begin
                if (rx_prev_reg && !rx_sync_reg) begin
                    rx_busy_reg <= 1'b1;
                    rx_cnt_reg  <= '0;
                    rx_bit_reg  <= '0;
                end
            end else if (rx_bit_reg == 4'd0) begin
                // Mid-start-bit recheck: a line already back high was only a glitch.
                if (rx_cnt_reg == BIT_HALF) begin
                    rx_cnt_reg <= '0;
                    if (rx_sync_reg) begin
                        rx_busy_reg <= 1'b0;
                    end else begin
                        rx_bit_reg <= 4'd1;
                    end
                end else begin
                    rx_cnt_reg <= rx_cnt_reg + 1'b1;
                end
            end else if (rx_cnt_reg == BIT_LAST) begin
                rx_cnt_reg <= '0;
                if (rx_bit_reg == BIT_STOP) begin
                    rx_busy_reg <= 1'b0;
                    rx_done_reg <= rx_sync_reg;
                end else begin
                    rx_shift_reg <= {rx_sync_reg, rx_shift_reg[7:1]};
                    rx_bit_reg   <= rx_bit_reg + 1'b1;
                end
            end else begin
                rx_cnt_reg <= rx_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            op_reg       <= '0;
            arg_reg      <= '0;
            bit_cnt_reg  <= '0;
            bit_idx_reg  <= '0;
            byte_idx_reg <= '0;
            tmo_cnt_reg  <= '0;
            uart_tx_o    <= 1'b1;
            cmd_ready_o  <= 1'b1;
            busy_o       <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_status_o <= 2'b00;
            rsp_byte_o   <= 8'h00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid_i && cmd_ready_o) begin
                        op_reg       <= cmd_op_i;
                        arg_reg      <= cmd_arg_i;
                        byte_idx_reg <= '0;
                        // One idle cycle before the first start bit.
                        bit_idx_reg  <= BIT_PRE;
                        bit_cnt_reg  <= BIT_LAST;
                        cmd_ready_o  <= 1'b0;
                        busy_o       <= 1'b1;
                        state_reg    <= SEND;
                    end
                end
                SEND: begin
                    if (bit_cnt_reg != BIT_LAST) begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end else begin
                        bit_cnt_reg <= '0;
                        if (bit_idx_reg == BIT_PRE) begin
                            bit_idx_reg <= '0;
                            uart_tx_o   <= 1'b0;
                        end else if (bit_idx_reg == BIT_STOP) begin
                            if (byte_idx_reg == BYTE_LAST) begin
                                tmo_cnt_reg <= '0;
                                state_reg   <= WAIT_RSP;
                            end else begin
                                byte_idx_reg <= byte_idx_reg + 1'b1;
                                bit_idx_reg  <= '0;
                                uart_tx_o    <= 1'b0;
                            end
                        end else begin
                            bit_idx_reg <= bit_idx_reg + 1'b1;
                            uart_tx_o   <= (bit_idx_reg == 4'd8) ? 1'b1 : cur_byte[bit_idx_reg[2:0]];
                        end
                    end
                end
                WAIT_RSP: begin
                    // A byte finishing on the timeout cycle takes priority.
                    if (rx_done_reg) begin
                        rsp_byte_o   <= rx_shift_reg;
                        rsp_status_o <= (rx_shift_reg == 8'h06) ? 2'b00 :
                                        (rx_shift_reg == 8'h15) ? 2'b01 : 2'b11;
                        rsp_valid_o  <= 1'b1;
                        state_reg    <= REPORT;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        rsp_byte_o   <= 8'h00;
                        rsp_status_o <= 2'b10;
                        rsp_valid_o  <= 1'b1;
                        state_reg    <= REPORT;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                REPORT: begin
                    rsp_valid_o <= 1'b0;
                    busy_o      <= 1'b0;
                    cmd_ready_o <= 1'b1;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_glitch_cmd_host.sv
// Directed bench for glitch_cmd_host: scoreboard queues for transmitted bytes and responses.
module tb_glitch_cmd_host;
    localparam int CLK_FREQ  = 3_200_000;
    localparam int BAUD_RATE = 100_000;
    localparam int T_CYC     = 5000;
    localparam int B         = CLK_FREQ / BAUD_RATE;
`ifdef GLITCH_CMD_CHECKSUM_EN
    localparam int NB = 6;
`else
    localparam int NB = 5;
`endif

    typedef struct {
        logic [1:0] st;
        logic [7:0] b;
        int         at;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [7:0]  cmd_op_i;
    logic [31:0] cmd_arg_i;
    logic        uart_tx_o;
    logic        uart_rx_i;
    logic        rsp_valid_o;
    logic [1:0]  rsp_status_o;
    logic [7:0]  rsp_byte_o;
    logic        busy_o;

    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   accept_cyc = 0;
    int   accept_count = 0;
    int   exp_fall_cyc = 0;
    int   rst_count = 0;
    logic [7:0] tx_q[$];
    rsp_t       rsp_q[$];

    glitch_cmd_host #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD_RATE(BAUD_RATE),
        .TIMEOUT_CYCLES(T_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i),
        .cmd_arg_i(cmd_arg_i),
        .uart_tx_o(uart_tx_o),
        .uart_rx_i(uart_rx_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_status_o(rsp_status_o),
        .rsp_byte_o(rsp_byte_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] op, input logic [31:0] arg);
        tx_q.push_back(op);
        for (int i = 0; i < 4; i++) tx_q.push_back(arg[8*i +: 8]);
`ifdef GLITCH_CMD_CHECKSUM_EN
        tx_q.push_back(op ^ arg[7:0] ^ arg[15:8] ^ arg[23:16] ^ arg[31:24]);
`endif
    endtask

    task automatic push_rsp(input logic [1:0] st, input logic [7:0] b, input int at);
        rsp_t e;
        e.st = st;
        e.b  = b;
        e.at = at;
        rsp_q.push_back(e);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] arg);
        int guard;
        @(negedge clk);
        cmd_op_i    = op;
        cmd_arg_i   = arg;
        cmd_valid_i = 1'b1;
        guard = 0;
        while (cmd_ready_o !== 1'b1 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_ready_before_accept", 32'(cmd_ready_o), 32'd1);
        accept_cyc   = cyc + 1;
        exp_fall_cyc = accept_cyc + 1;
        accept_count++;
        push_frame(op, arg);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        check("busy_ready_after_accept", 32'({busy_o, cmd_ready_o}), 32'h2);
    endtask

    task automatic wait_frame_done();
        int target;
        target = accept_cyc + 1 + NB * 10 * B + 4;
        while (cyc < target) @(negedge clk);
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx_i = 1'b0;
        repeat (B) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            uart_rx_i = b[k];
            repeat (B) @(negedge clk);
        end
        uart_rx_i = stop;
        repeat (B) @(negedge clk);
        uart_rx_i = 1'b1;
        repeat (B) @(negedge clk);
    endtask

    task automatic wait_idle_and_hold(input logic [1:0] st, input logic [7:0] b);
        int guard;
        guard = 0;
        while (busy_o !== 1'b0 && guard < 8000) begin
            @(negedge clk);
            guard++;
        end
        check("idle_reached", 32'(busy_o), 32'd0);
        repeat (5) @(negedge clk);
        check("rsp_hold", 32'({rsp_status_o, rsp_byte_o}), 32'({st, b}));
    endtask

    // Decodes every frame seen on uart_tx_o and pops the scoreboard.
    initial begin : tx_monitor
        logic       prev;
        logic [7:0] got;
        logic [7:0] want;
        logic       start_b;
        logic       stop_b;
        int         seen_accepts;
        int         rst_at_start;
        prev = 1'b1;
        seen_accepts = 0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && prev && uart_tx_o === 1'b0) begin
                rst_at_start = rst_count;
                if (seen_accepts != accept_count) begin
                    check("first_start_cycle", 32'(cyc), 32'(exp_fall_cyc));
                    seen_accepts = accept_count;
                end
                repeat (B/2) @(negedge clk);
                start_b = uart_tx_o;
                for (int k = 0; k < 8; k++) begin
                    repeat (B) @(negedge clk);
                    got[k] = uart_tx_o;
                end
                repeat (B) @(negedge clk);
                stop_b = uart_tx_o;
                if (rst_at_start == rst_count) begin
                    check("tx_byte_expected", 32'(tx_q.size() != 0), 32'd1);
                    want = 8'h00;
                    if (tx_q.size() != 0) want = tx_q.pop_front();
                    check("tx_byte", 32'(got), 32'(want));
                    check("tx_start_stop", 32'({start_b, stop_b}), 32'h1);
                end
            end
            prev = uart_tx_o;
        end
    end

    initial begin : rsp_monitor
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid_o === 1'b1) begin
                check("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
                if (rsp_q.size() != 0) begin
                    e = rsp_q.pop_front();
                    check("rsp_status", 32'(rsp_status_o), 32'(e.st));
                    check("rsp_byte", 32'(rsp_byte_o), 32'(e.b));
                    if (e.at >= 0) check("rsp_cycle", 32'(cyc), 32'(e.at));
                end
                @(negedge clk);
                check("rsp_pulse_width", 32'(rsp_valid_o), 32'd0);
            end
        end
    end

    initial begin : watchdog
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog cycle budget expired observed=%0d tests_run=%0d", cyc, tests_run);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst_n       = 1'b0;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 8'h00;
        cmd_arg_i   = 32'h0;
        uart_rx_i   = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(uart_tx_o), 32'd1);
        check("reset_ready", 32'(cmd_ready_o), 32'd1);
        check("reset_busy", 32'(busy_o), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("reset_rsp_fields", 32'({rsp_status_o, rsp_byte_o}), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Reference frame, ACK
        send_cmd(8'h41, 32'h12345678);
        wait_frame_done();
        push_rsp(2'b00, 8'h06, -1);
        rx_byte(8'h06, 1'b1);
        wait_idle_and_hold(2'b00, 8'h06);

        // NAK
        send_cmd(8'hA5, 32'hDEADBEEF);
        wait_frame_done();
        push_rsp(2'b01, 8'h15, -1);
        rx_byte(8'h15, 1'b1);
        wait_idle_and_hold(2'b01, 8'h15);

        // Unexpected byte
        send_cmd(8'h3C, 32'h00000000);
        wait_frame_done();
        push_rsp(2'b11, 8'hAA, -1);
        rx_byte(8'hAA, 1'b1);
        wait_idle_and_hold(2'b11, 8'hAA);

        // Timeout, exact cycle of the pulse
        send_cmd(8'h7E, 32'hCAFEF00D);
        push_rsp(2'b10, 8'h00, accept_cyc + 1 + NB * 10 * B + T_CYC);
        wait_idle_and_hold(2'b10, 8'h00);

        // Glitch on rx, then a framing-error byte, then a good ACK
        send_cmd(8'h11, 32'h01020304);
        wait_frame_done();
        push_rsp(2'b00, 8'h06, -1);
        uart_rx_i = 1'b0;
        repeat (10) @(negedge clk);
        uart_rx_i = 1'b1;
        repeat (3 * B) @(negedge clk);
        rx_byte(8'h15, 1'b0);
        check("busy_after_framing_err", 32'(busy_o), 32'd1);
        rx_byte(8'h06, 1'b1);
        wait_idle_and_hold(2'b00, 8'h06);

        // Back-pressure and an echo byte during SEND
        send_cmd(8'h22, 32'h0BADF00D);
        @(negedge clk);
        cmd_op_i    = 8'hFF;
        cmd_valid_i = 1'b1;
        repeat (5) @(negedge clk);
        check("ready_low_in_send", 32'(cmd_ready_o), 32'd0);
        rx_byte(8'h06, 1'b1);
        cmd_valid_i = 1'b0;
        check("still_busy_in_send", 32'(busy_o), 32'd1);
        wait_frame_done();
        push_rsp(2'b01, 8'h15, -1);
        rx_byte(8'h15, 1'b1);
        wait_idle_and_hold(2'b01, 8'h15);

        // Reset in the middle of byte 2
        send_cmd(8'h55, 32'h89ABCDEF);
        while (cyc < accept_cyc + 1 + 2 * 10 * B + 3 * B) @(negedge clk);
        rst_count++;
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_tx_high", 32'(uart_tx_o), 32'd1);
        check("abort_idle_outputs", 32'({cmd_ready_o, busy_o, rsp_valid_o}), 32'h4);
        tx_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12 * B) @(negedge clk);
        check("post_abort_tx_high", 32'(uart_tx_o), 32'd1);
        check("post_abort_busy", 32'(busy_o), 32'd0);

        // Normal command after abort
        send_cmd(8'h41, 32'h12345678);
        wait_frame_done();
        push_rsp(2'b00, 8'h06, -1);
        rx_byte(8'h06, 1'b1);
        wait_idle_and_hold(2'b00, 8'h06);

        repeat (2 * B) @(negedge clk);
        check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
        check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
